// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : PC owner, imem request/ack port and IF/DEC pipeline register.
// Optional macro FETCH_BUBBLE_CNT_EN builds the saturating decode-bubble counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter int unsigned DBITS    = 32,
  parameter logic [DBITS-1:0] START_PC = 32'h40
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             imem_req,
  output logic [DBITS-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [DBITS-1:0] imem_rdata,
  output logic [DBITS-1:0] IF_pc,
  output logic [3:0]       IF_op,
  input  logic             IF_stall,
  input  logic [DBITS-1:0] pcImm,
  input  logic             ex_redirect,
  input  logic [DBITS-1:0] ex_target,
  output logic             DEC_valid,
  output logic [DBITS-1:0] DEC_inst,
  output logic [DBITS-1:0] DEC_pc,
  output logic [3:0]       DEC_op,
  input  logic             dec_ready,
  output logic [31:0]      bubble_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    DISCARD  = 2'd2,
    WAIT_DEC = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DBITS-1:0] pc_q, pc_d;
  logic [DBITS-1:0] pending_q, pending_d;
  logic [DBITS-1:0] skid_inst_q, skid_inst_d;
  logic [DBITS-1:0] skid_pc_q, skid_pc_d;
  logic             req_q, req_d;
  logic             dec_valid_q, dec_valid_d;
  logic [DBITS-1:0] dec_inst_q, dec_inst_d;
  logic [DBITS-1:0] dec_pc_q, dec_pc_d;

  logic             w_ack;
  logic             w_slot_free;
  logic             w_load;
  logic [DBITS-1:0] w_load_inst;
  logic [DBITS-1:0] w_load_pc;
  logic [DBITS-1:0] w_pc_seq;

  assign w_ack       = imem_ack && req_q;
  assign w_slot_free = !dec_valid_q || dec_ready;
  assign w_pc_seq    = IF_stall ? (pc_q + DBITS'(4)) : pcImm;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pending_d   = pending_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    w_load      = 1'b0;
    w_load_inst = imem_rdata;
    w_load_pc   = pc_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (w_ack) begin
          if (ex_redirect) begin
            pc_d = ex_target;
          end else begin
            pc_d = w_pc_seq;
            if (w_slot_free) begin
              w_load = 1'b1;
            end else begin
              skid_inst_d = imem_rdata;
              skid_pc_d   = pc_q;
              state_d     = WAIT_DEC;
            end
          end
        end else if (ex_redirect) begin
          pending_d = ex_target;
          state_d   = DISCARD;
        end
      end
      DISCARD: begin
        if (w_ack) begin
          pc_d    = ex_redirect ? ex_target : pending_q;
          state_d = REQ;
        end else if (ex_redirect) begin
          pending_d = ex_target;
        end
      end
      WAIT_DEC: begin
        if (ex_redirect) begin
          pc_d    = ex_target;
          state_d = REQ;
        end else if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_inst = skid_inst_q;
          w_load_pc   = skid_pc_q;
          state_d     = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush always wins over a same-cycle load into the decode register.
  always_comb begin
    dec_valid_d = dec_valid_q;
    dec_inst_d  = dec_inst_q;
    dec_pc_d    = dec_pc_q;
    if (ex_redirect) begin
      dec_valid_d = 1'b0;
    end else if (w_load) begin
      dec_valid_d = 1'b1;
      dec_inst_d  = w_load_inst;
      dec_pc_d    = w_load_pc;
    end else if (dec_ready) begin
      dec_valid_d = 1'b0;
    end
  end

  assign req_d = (state_d == REQ) || (state_d == DISCARD);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= START_PC;
      pending_q   <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      req_q       <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_inst_q  <= '0;
      dec_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pending_q   <= pending_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      req_q       <= req_d;
      dec_valid_q <= dec_valid_d;
      dec_inst_q  <= dec_inst_d;
      dec_pc_q    <= dec_pc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign IF_pc     = pc_q;
  assign IF_op     = (reset_n && (state_q == REQ) && w_ack) ? imem_rdata[DBITS-1 -: 4] : 4'b0000;
  assign DEC_valid = dec_valid_q;
  assign DEC_inst  = dec_inst_q;
  assign DEC_pc    = dec_pc_q;
  assign DEC_op    = dec_inst_q[DBITS-1 -: 4];

`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bubble_q <= '0;
    end else if ((state_q != IDLE) && !dec_valid_q && (bubble_q != 32'hFFFF_FFFF)) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_q;
`else
  assign bubble_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : directed self-checking bench for fetch_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IF_pc;
  logic [3:0]  IF_op;
  logic        IF_stall;
  logic [31:0] pcImm;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        DEC_valid;
  logic [31:0] DEC_inst;
  logic [31:0] DEC_pc;
  logic [3:0]  DEC_op;
  logic        dec_ready;
  logic [31:0] bubble_cnt;

  logic        auto_ack;
  logic [31:0] jal_addr;
  int          n_cmp;
  int          n_bad;

  fetch_stage #(.DBITS(32), .START_PC(32'h40)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .IF_pc      (IF_pc),
    .IF_op      (IF_op),
    .IF_stall   (IF_stall),
    .pcImm      (pcImm),
    .ex_redirect(ex_redirect),
    .ex_target  (ex_target),
    .DEC_valid  (DEC_valid),
    .DEC_inst   (DEC_inst),
    .DEC_pc     (DEC_pc),
    .DEC_op     (DEC_op),
    .dec_ready  (dec_ready),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait memory: word = {opcode, addr[27:0]}, JAL opcode only at jal_addr.
  assign imem_ack   = auto_ack && imem_req;
  assign imem_rdata = (imem_addr == jal_addr) ? {4'b0110, imem_addr[27:0]}
                                              : {4'b0001, imem_addr[27:0]};
  assign IF_stall   = (IF_op != 4'b0110);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    reset_n     = 1'b0;
    auto_ack    = 1'b0;
    jal_addr    = 32'hFFFF_FFF0;
    pcImm       = 32'h100;
    ex_redirect = 1'b0;
    ex_target   = 32'h0;
    dec_ready   = 1'b1;

    // Reset values
    step(); step(); step();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h40);
    chk("rst_ifpc", IF_pc, 32'h40);
    chk("rst_ifop", {28'b0, IF_op}, 32'h0);
    chk("rst_decv", {31'b0, DEC_valid}, 32'h0);
    chk("rst_deci", DEC_inst, 32'h0);
    chk("rst_decpc", DEC_pc, 32'h0);
    chk("rst_decop", {28'b0, DEC_op}, 32'h0);
    chk("rst_bub", bubble_cnt, 32'h0);

    // Sequential zero-wait fetch
    auto_ack = 1'b1;
    reset_n  = 1'b1;
    #1;
    chk("idle_req", {31'b0, imem_req}, 32'h0);
    step();
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("seq_a0", imem_addr, 32'h40);
    chk("seq_ifop", {28'b0, IF_op}, 32'h1);
    step();
    chk("seq_a1", imem_addr, 32'h44);
    chk("seq_v1", {31'b0, DEC_valid}, 32'h1);
    chk("seq_d1", DEC_pc, 32'h40);
    chk("seq_i1", DEC_inst, 32'h1000_0040);
    step();
    chk("seq_a2", imem_addr, 32'h48);
    chk("seq_d2", DEC_pc, 32'h44);
    step();
    chk("seq_a3", imem_addr, 32'h4C);
    chk("seq_d3", DEC_pc, 32'h48);

    // JAL at 0x44 redirects to pcImm
    jal_addr = 32'h44;
    pcImm    = 32'h100;
    do_reset();
    chk("jal_a0", imem_addr, 32'h40);
    step();
    chk("jal_a1", imem_addr, 32'h44);
    chk("jal_d0", DEC_pc, 32'h40);
    chk("jal_ifop", {28'b0, IF_op}, 32'h6);
    step();
    chk("jal_tgt", imem_addr, 32'h100);
    chk("jal_d1", DEC_pc, 32'h44);
    chk("jal_decop", {28'b0, DEC_op}, 32'h6);
    step();
    chk("jal_d2", DEC_pc, 32'h100);
    chk("jal_a2", imem_addr, 32'h104);

    // ex_redirect while request to 0x48 waits
    jal_addr = 32'hFFFF_FFF0;
    do_reset();
    step();
    step();
    chk("dis_a48", imem_addr, 32'h48);
    auto_ack  = 1'b0;
    dec_ready = 1'b0;
    step(); step(); step();
    chk("dis_hold", imem_addr, 32'h48);
    chk("dis_v", {31'b0, DEC_valid}, 32'h1);
    ex_redirect = 1'b1;
    ex_target   = 32'h200;
    step();
    ex_redirect = 1'b0;
    dec_ready   = 1'b1;
    chk("dis_flushv", {31'b0, DEC_valid}, 32'h0);
    chk("dis_addr", imem_addr, 32'h48);
    chk("dis_req", {31'b0, imem_req}, 32'h1);
    step();
    chk("dis_addr2", imem_addr, 32'h48);
    auto_ack = 1'b1;
    step();
    chk("dis_tgt", imem_addr, 32'h200);
    chk("dis_drop", {31'b0, DEC_valid}, 32'h0);
    step();
    chk("dis_dpc", DEC_pc, 32'h200);
    chk("dis_a204", imem_addr, 32'h204);

    // Decode back-pressure through the skid register
    do_reset();
    step();
    chk("wd_d0", DEC_pc, 32'h40);
    dec_ready = 1'b0;
    step();
    chk("wd_req", {31'b0, imem_req}, 32'h0);
    chk("wd_dpc", DEC_pc, 32'h40);
    step(); step(); step();
    chk("wd_req3", {31'b0, imem_req}, 32'h0);
    chk("wd_dpc3", DEC_pc, 32'h40);
    dec_ready = 1'b1;
    step();
    chk("wd_dpc44", DEC_pc, 32'h44);
    chk("wd_resume", imem_addr, 32'h48);
    chk("wd_req1", {31'b0, imem_req}, 32'h1);
    step();
    chk("wd_dpc48", DEC_pc, 32'h48);

    // ex_redirect beats a same-cycle JAL ack
    jal_addr = 32'h40;
    pcImm    = 32'h100;
    do_reset();
    ex_redirect = 1'b1;
    ex_target   = 32'h300;
    #1;
    chk("pri_ifop", {28'b0, IF_op}, 32'h6);
    step();
    ex_redirect = 1'b0;
    chk("pri_pc", IF_pc, 32'h300);
    chk("pri_nolatch", {31'b0, DEC_valid}, 32'h0);
    step();
    chk("pri_dpc", DEC_pc, 32'h300);
    chk("pri_a304", imem_addr, 32'h304);

    // PC wraps modulo 2^32
    ex_redirect = 1'b1;
    ex_target   = 32'hFFFF_FFFC;
    step();
    ex_redirect = 1'b0;
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_zero", imem_addr, 32'h0);
    chk("wrap_dpc", DEC_pc, 32'hFFFF_FFFC);

    // Reset mid-request at 0x80, ack in the reset cycle ignored
    jal_addr = 32'h40;
    pcImm    = 32'h80;
    do_reset();
    step();
    chk("mr_a80", imem_addr, 32'h80);
    auto_ack = 1'b0;
    step();
    auto_ack = 1'b1;
    reset_n  = 1'b0;
    #1;
    chk("mr_ifop", {28'b0, IF_op}, 32'h0);
    step();
    chk("mr_req", {31'b0, imem_req}, 32'h0);
    chk("mr_addr", imem_addr, 32'h40);
    chk("mr_decv", {31'b0, DEC_valid}, 32'h0);
    chk("mr_decpc", DEC_pc, 32'h0);
    chk("mr_deci", DEC_inst, 32'h0);
    chk("mr_bub", bubble_cnt, 32'h0);

    // Bubble counter with memory never acking
    jal_addr = 32'hFFFF_FFF0;
    auto_ack = 1'b0;
    reset_n  = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
`ifdef FETCH_BUBBLE_CNT_EN
    chk("bub_cnt", bubble_cnt, 32'd5);
`else
    chk("bub_cnt", bubble_cnt, 32'd0);
`endif
    chk("bub_hold", imem_addr, 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
